mod_n_counter: RTL and testbench
================================

MOD_N_COUNTER -- requirements
Module: mod_n_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 3, counter and modulus width in bits (>=2).
REQ-002 SHALL have parameter MOD_DEFAULT, default 5, modulus after reset (2..2^WIDTH).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  count enable; one step per cycle when high.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 clr  input  1  synchronous clear of count and halt state.
REQ-008 load  input  1  synchronous load of load_val into count.
REQ-009 load_val  input  WIDTH  value for load.
REQ-010 mod_wr  input  1  write strobe for modulus register.
REQ-011 mod_val  input  WIDTH+1  new modulus.
REQ-012 oneshot  input  1  mode: 1 = halt after first wrap, 0 = free-running.
REQ-013 count  output  WIDTH  registered current count.
REQ-014 carry  output  1  combinational: en & ~halted & count at terminal value; used for cascading.
REQ-015 wrap  output  1  registered one-cycle pulse in the cycle after a wrap.
REQ-016 halted  output  1  registered; high while stopped in oneshot mode.
REQ-017 cfg_err  output  1  registered sticky flag for rejected modulus or load value.

Function
REQ-018 Modulus register mod_q SHALL hold modulus M. Count range SHALL be 0..M-1.
REQ-019 Terminal value SHALL be M-1 when up=1 and 0 when up=0.
REQ-020 Per-cycle priority SHALL be clr > load > en step. clr SHALL set count=0 and halted=0.
REQ-021 load SHALL set count=load_val if load_val<M, and clear halted. If load_val>=M, load SHALL set count=0, clear halted and set cfg_err.
REQ-022 Step up SHALL be count+1, wrapping M-1->0. Step down SHALL be count-1, wrapping 0->M-1.
REQ-023 A wrap SHALL assert wrap for exactly the following cycle. Arithmetic SHALL be done at WIDTH+1 bits so that M=2^WIDTH wraps correctly.
REQ-024 en SHALL be ignored while halted=1. count SHALL then hold.
REQ-025 FSM with states RUN and HALT:
  - RUN->HALT on a wrap while oneshot=1.
  - HALT->RUN on clr or load.
  - halted=1 exactly in HALT.
REQ-026 A mod_wr with 2<=mod_val<=2^WIDTH SHALL update mod_q at the clock edge. The new M SHALL govern steps from the next cycle. The same-cycle step SHALL use the old M.
REQ-027 A mod_wr with mod_val outside 2..2^WIDTH SHALL leave mod_q unchanged and set cfg_err.
REQ-028 If a valid mod_wr leaves count>=new M, count SHALL be forced to 0 on the next edge. This SHALL override the en step but not clr or load.
REQ-029 cfg_err SHALL clear only on clr, on a valid mod_wr, or on reset.
REQ-030 Changing up mid-count SHALL take effect on the same cycle's step, with no lost or extra counts.

Reset
REQ-031 While rst=0 the block SHALL hold: count=0, mod_q=MOD_DEFAULT, state RUN, halted=0, wrap=0, cfg_err=0.
REQ-032 Reset assertion SHALL take effect immediately, independent of clk. Reset release SHALL allow counting from the first rising edge.
REQ-033 Reset asserted mid-operation, including in HALT, SHALL abort to the REQ-031 values.

Structure
REQ-034 A shared package SHALL hold the RUN/HALT state encoding and a MOD_MIN=2 constant.
REQ-035 The next-count arithmetic (wrap and direction) SHALL be a combinational sub-module, mod_n_step. The top module SHALL hold the registers and the FSM.

Verification
REQ-036 WIDTH=3, M=5, up=1, en=1 for 12 cycles after reset -> count 0,1,2,3,4,0,1,2,3,4,0,1; wrap high after each 4->0; carry high whenever count=4.
REQ-037 up=0 from count=0, en=1 -> count 4,3,2,1,0,4; wrap pulses after 0->4.
REQ-038 oneshot=1, M=5, count up from 0 -> count reaches 0 after 4, halted=1, then en held 5 cycles leaves count=0; load with load_val=2 -> count=2, halted=0.
REQ-039 count=6 with M=8, then mod_wr with mod_val=5 -> next count=0; mod_wr with mod_val=1 -> mod_q unchanged, cfg_err=1; load with load_val=7 while M=5 -> count=0, cfg_err=1.
REQ-040 clr and load asserted together with en at count=3 -> count=0. rst dropped mid-count in HALT -> count=0, halted=0, mod_q=5 immediately.
REQ-041 WIDTH=3, mod_val=8 -> count 0..7 then wraps to 0 with a wrap pulse.

Source files
------------

// File: rtl/mod_n_counter_pkg.sv
// Shared constants for the modulo-N counter: FSM encoding and modulus lower bound.
package mod_n_counter_pkg;

   // Two-state run/halt FSM, kept as plain constants for legacy tool compatibility.
   localparam logic [0:0] StRun  = 1'b0;
   localparam logic [0:0] StHalt = 1'b1;

   // Smallest modulus accepted by the modulus register.
   localparam int unsigned MOD_MIN = 2;

endpackage : mod_n_counter_pkg

// File: rtl/mod_n_step.sv
// Combinational next-count for a modulo-M up/down counter.
// All arithmetic is done at WIDTH+1 bits so that M = 2^WIDTH wraps cleanly.
module mod_n_step #(
   parameter int unsigned WIDTH = 3
) (
   input  logic [WIDTH-1:0] count_i,
   input  logic [WIDTH:0]   mod_i,
   input  logic             up_i,
   output logic [WIDTH:0]   next_o,
   output logic             at_term_o
);

   logic [WIDTH:0] cnt_ext;
   logic [WIDTH:0] top_val;

   // Terminal detect and wrapping increment/decrement.
   always_comb begin
      cnt_ext   = {1'b0, count_i};
      top_val   = mod_i - 1'b1;
      at_term_o = up_i ? (cnt_ext == top_val) : (cnt_ext == '0);
      if (up_i) begin
         next_o = at_term_o ? '0 : cnt_ext + 1'b1;
      end else begin
         next_o = at_term_o ? top_val : cnt_ext - 1'b1;
      end
   end

endmodule : mod_n_step

// File: rtl/mod_n_counter.sv
// Programmable modulo-N up/down counter with oneshot halt, cascade carry,
// wrap pulse and sticky configuration-error flag.
module mod_n_counter
   import mod_n_counter_pkg::*;
#(
   parameter int unsigned WIDTH       = 3,
   parameter int unsigned MOD_DEFAULT = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mod_wr,
   input  logic [WIDTH:0]   mod_val,
   input  logic             oneshot,
   output logic [WIDTH-1:0] count,
   output logic             carry,
   output logic             wrap,
   output logic             halted,
   output logic             cfg_err
);

   localparam logic [WIDTH:0] ModMin   = (WIDTH + 1)'(MOD_MIN);
   localparam logic [WIDTH:0] ModMax   = {1'b1, {WIDTH{1'b0}}};
   localparam logic [WIDTH:0] ModReset = (WIDTH + 1)'(MOD_DEFAULT);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH:0]   mod_q, mod_d;
   logic [0:0]       state_q, state_d;
   logic             wrap_q, wrap_d;
   logic             cfg_err_q, cfg_err_d;

   logic [WIDTH:0]   step_next;
   logic             at_term;
   logic             is_halted;
   logic             step_en;
   logic             mod_ok;
   logic [WIDTH:0]   count_step;

   mod_n_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .count_i   (count_q),
      .mod_i     (mod_q),
      .up_i      (up),
      .next_o    (step_next),
      .at_term_o (at_term)
   );

   assign is_halted = (state_q == StHalt);
   assign step_en   = en & ~is_halted;
   assign mod_ok    = (mod_val >= ModMin) && (mod_val <= ModMax);
   // Count this edge would hold absent clr/load; checked against a new modulus below.
   assign count_step = step_en ? step_next : {1'b0, count_q};

   // Next-state: clr > load > modulus-shrink reset > enabled step.
   always_comb begin
      count_d   = count_q;
      mod_d     = mod_q;
      state_d   = state_q;
      wrap_d    = 1'b0;
      cfg_err_d = cfg_err_q;

      if (mod_wr) begin
         if (mod_ok) begin
            mod_d     = mod_val;
            cfg_err_d = 1'b0;
         end else begin
            cfg_err_d = 1'b1;
         end
      end

      if (clr) begin
         count_d   = '0;
         state_d   = StRun;
         cfg_err_d = 1'b0;
      end else if (load) begin
         state_d = StRun;
         if ({1'b0, load_val} < mod_q) begin
            count_d = load_val;
         end else begin
            count_d   = '0;
            cfg_err_d = 1'b1;
         end
      end else begin
         if (step_en) begin
            count_d = step_next[WIDTH-1:0];
            if (at_term) begin
               wrap_d = 1'b1;
               if (oneshot) begin
                  state_d = StHalt;
               end
            end
         end
         // A shrinking modulus must never leave the count out of range.
         if (mod_wr && mod_ok && (count_step >= mod_val)) begin
            count_d = '0;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q   <= '0;
         mod_q     <= ModReset;
         state_q   <= StRun;
         wrap_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         mod_q     <= mod_d;
         state_q   <= state_d;
         wrap_q    <= wrap_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign count   = count_q;
   assign carry   = step_en & at_term;
   assign wrap    = wrap_q;
   assign halted  = is_halted;
   assign cfg_err = cfg_err_q;

endmodule : mod_n_counter

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter (WIDTH=3, MOD_DEFAULT=5).
module tb_mod_n_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up;
   logic       clr;
   logic       load;
   logic [2:0] load_val;
   logic       mod_wr;
   logic [3:0] mod_val;
   logic       oneshot;
   logic [2:0] count;
   logic       carry;
   logic       wrap;
   logic       halted;
   logic       cfg_err;

   int total;
   int bad;

   mod_n_counter #(
      .WIDTH       (3),
      .MOD_DEFAULT (5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .mod_wr   (mod_wr),
      .mod_val  (mod_val),
      .oneshot  (oneshot),
      .count    (count),
      .carry    (carry),
      .wrap     (wrap),
      .halted   (halted),
      .cfg_err  (cfg_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
      mod_wr = 1'b0; mod_val = '0; oneshot = 1'b0;

      // Reset values
      #3;
      check("rst_count", count, 0);
      check("rst_halted", halted, 0);
      check("rst_wrap", wrap, 0);
      check("rst_cfg_err", cfg_err, 0);
      #9 rst = 1'b1;

      // Count up, M=5, 12 cycles
      en = 1'b1; up = 1'b1;
      for (int i = 0; i < 12; i++) begin
         check($sformatf("up_count%0d", i), count, i % 5);
         check($sformatf("up_carry%0d", i), carry, (i % 5 == 4) ? 1 : 0);
         check($sformatf("up_wrap%0d", i), wrap, (i > 0 && i % 5 == 0) ? 1 : 0);
         tick();
      end
      check("up_end", count, 2);

      // Count down from 0
      clr = 1'b1; tick(); clr = 1'b0;
      check("clr_to0", count, 0);
      up = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("dn_count%0d", i), count, (5 - i % 5) % 5);
         check($sformatf("dn_wrap%0d", i), wrap, (i == 1 || i == 6) ? 1 : 0);
      end

      // Oneshot halt
      clr = 1'b1; tick(); clr = 1'b0;
      up = 1'b1; oneshot = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("os_at4", count, 4);
      check("os_run", halted, 0);
      tick();
      check("os_wrapped", count, 0);
      check("os_halted", halted, 1);
      check("os_wrap", wrap, 1);
      for (int i = 0; i < 5; i++) tick();
      check("os_hold", count, 0);
      check("os_still_halted", halted, 1);
      check("os_no_wrap", wrap, 0);
      up = 1'b0;
      #1 check("os_carry_gated", carry, 0);
      up = 1'b1;
      load = 1'b1; load_val = 3'd2; tick(); load = 1'b0;
      check("os_load_count", count, 2);
      check("os_load_run", halted, 0);
      oneshot = 1'b0;

      // Modulus changes and config errors
      en = 1'b0;
      mod_wr = 1'b1; mod_val = 4'd8; tick(); mod_wr = 1'b0;
      load = 1'b1; load_val = 3'd6; tick(); load = 1'b0;
      check("m8_load6", count, 6);
      mod_wr = 1'b1; mod_val = 4'd5; tick();
      check("shrink_to0", count, 0);
      check("shrink_no_err", cfg_err, 0);
      mod_val = 4'd1; tick(); mod_wr = 1'b0;
      check("bad_mod_err", cfg_err, 1);
      en = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("keep_m5_at4", count, 4);
      tick();
      check("keep_m5_wrap", count, 0);
      check("keep_m5_wrap_pulse", wrap, 1);
      check("err_sticky", cfg_err, 1);
      en = 1'b0;
      clr = 1'b1; tick(); clr = 1'b0;
      check("clr_err", cfg_err, 0);
      load = 1'b1; load_val = 3'd7; tick(); load = 1'b0;
      check("bad_load_count", count, 0);
      check("bad_load_err", cfg_err, 1);
      mod_wr = 1'b1; mod_val = 4'd5; tick(); mod_wr = 1'b0;
      check("good_mod_clears_err", cfg_err, 0);
      mod_wr = 1'b1; mod_val = 4'd9; tick(); mod_wr = 1'b0;
      check("mod9_err", cfg_err, 1);

      // clr and load together with en
      load = 1'b1; load_val = 3'd3; tick();
      check("load3", count, 3);
      clr = 1'b1; load_val = 3'd2; en = 1'b1; tick();
      clr = 1'b0; load = 1'b0;
      check("clr_beats_load", count, 0);
      check("clr_beats_load_err", cfg_err, 0);

      // Reset asynchronously while halted with M=8
      en = 1'b0;
      mod_wr = 1'b1; mod_val = 4'd8; tick(); mod_wr = 1'b0;
      en = 1'b1; oneshot = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check("m8_halted", halted, 1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_count", count, 0);
      check("async_rst_halted", halted, 0);
      check("async_rst_wrap", wrap, 0);
      #2 rst = 1'b1;
      oneshot = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("post_rst_at4", count, 4);
      tick();
      check("post_rst_m5", count, 0);
      check("post_rst_wrap", wrap, 1);

      // Full-range modulus 2^WIDTH
      en = 1'b0;
      mod_wr = 1'b1; mod_val = 4'd8; tick(); mod_wr = 1'b0;
      en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check($sformatf("m8_count%0d", i), count, i % 8);
         check($sformatf("m8_wrap%0d", i), wrap, (i == 8) ? 1 : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mod_n_counter
